// File: rtl/branch_unit.sv
// Multi-cycle control-transfer unit: resolves RISC-V B-type branches, JAL and JALR
// through an IDLE -> READ -> EXEC -> RESP sequence with valid/ready on both sides.
module branch_unit #(
  parameter int XLEN           = 32,
  parameter int REG_SELECT_LEN = 5,
  parameter int C_EXT          = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_valid,
  output logic                      start_ready,
  input  logic [XLEN-1:0]           instruction,
  input  logic [XLEN-1:0]           program_counter,
  input  logic                      flush,
  output logic [REG_SELECT_LEN-1:0] register_1,
  output logic [REG_SELECT_LEN-1:0] register_2,
  input  logic [XLEN-1:0]           register_data_1,
  input  logic [XLEN-1:0]           register_data_2,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic                      load_new_program_counter,
  output logic [XLEN-1:0]           new_program_counter,
  output logic                      link_we,
  output logic [REG_SELECT_LEN-1:0] link_rd,
  output logic [XLEN-1:0]           link_data,
  output logic                      exception
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, RESP} state_t;

  localparam logic [XLEN-1:0] CLEAR_LSB = ~XLEN'(1);

  state_t r_state, w_nextState;

  logic [XLEN-1:0] r_instr, r_pc, r_operand1, r_operand2;
  logic            r_redirect, r_linkWe, r_exception;
  logic [XLEN-1:0] r_newPc, r_linkData;
  logic [REG_SELECT_LEN-1:0] r_linkRd;

  logic            w_accept;
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [XLEN-1:0] w_immB, w_immJ, w_immI, w_pcPlus4, w_target;
  logic            w_illegal, w_taken, w_isJump, w_misaligned;

  assign w_accept  = (r_state == IDLE) && start_valid && !flush;
  assign w_opcode  = r_instr[6:0];
  assign w_funct3  = r_instr[14:12];
  assign w_immB    = {{(XLEN-12){r_instr[31]}}, r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0};
  assign w_immJ    = {{(XLEN-20){r_instr[31]}}, r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0};
  assign w_immI    = {{(XLEN-11){r_instr[31]}}, r_instr[30:20]};
  assign w_pcPlus4 = r_pc + XLEN'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // flush overrides every transition, including a pending accept or response handoff
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (start_valid) w_nextState = READ;
      READ:    w_nextState = EXEC;
      EXEC:    w_nextState = RESP;
      RESP:    if (resp_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
    if (flush) w_nextState = IDLE;
  end

  always_comb begin
    w_illegal = 1'b1;
    w_taken   = 1'b0;
    w_isJump  = 1'b0;
    w_target  = w_pcPlus4;
    unique case (w_opcode)
      7'b1100011: begin
        w_target  = r_pc + w_immB;
        w_illegal = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
        unique case (w_funct3)
          3'b000:  w_taken = (r_operand1 == r_operand2);
          3'b001:  w_taken = (r_operand1 != r_operand2);
          3'b100:  w_taken = ($signed(r_operand1) <  $signed(r_operand2));
          3'b101:  w_taken = ($signed(r_operand1) >= $signed(r_operand2));
          3'b110:  w_taken = (r_operand1 <  r_operand2);
          3'b111:  w_taken = (r_operand1 >= r_operand2);
          default: w_taken = 1'b0;
        endcase
      end
      7'b1101111: begin
        w_illegal = 1'b0;
        w_taken   = 1'b1;
        w_isJump  = 1'b1;
        w_target  = r_pc + w_immJ;
      end
      7'b1100111: begin
        w_illegal = (w_funct3 != 3'b000);
        w_taken   = 1'b1;
        w_isJump  = 1'b1;
        w_target  = (r_operand1 + w_immI) & CLEAR_LSB;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Without the C extension a taken target must be 4-byte aligned
  assign w_misaligned = (C_EXT == 0) && w_taken && w_target[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr     <= '0;
      r_pc        <= '0;
      r_operand1  <= '0;
      r_operand2  <= '0;
      r_redirect  <= 1'b0;
      r_linkWe    <= 1'b0;
      r_exception <= 1'b0;
      r_newPc     <= '0;
      r_linkData  <= '0;
      r_linkRd    <= '0;
    end else begin
      if (w_accept) begin
        r_instr <= instruction;
        r_pc    <= program_counter;
      end
      if (r_state == READ) begin
        r_operand1 <= register_data_1;
        r_operand2 <= register_data_2;
      end
      if (r_state == EXEC) begin
        r_exception <= w_illegal || w_misaligned;
        r_redirect  <= !w_illegal && !w_misaligned && w_taken;
        r_linkWe    <= !w_illegal && !w_misaligned && w_isJump && (r_instr[11:7] != 5'd0);
        r_newPc     <= (!w_illegal && w_taken) ? w_target : w_pcPlus4;
        r_linkRd    <= w_isJump ? REG_SELECT_LEN'(r_instr[11:7]) : '0;
        r_linkData  <= w_isJump ? w_pcPlus4 : '0;
      end
    end
  end

  // Results are only visible while the response is offered; outside RESP they read as reset values
  always_comb begin
    start_ready              = (r_state == IDLE);
    resp_valid               = (r_state == RESP);
    register_1               = (r_state != IDLE) ? REG_SELECT_LEN'(r_instr[19:15]) : '0;
    register_2               = (r_state != IDLE) ? REG_SELECT_LEN'(r_instr[24:20]) : '0;
    load_new_program_counter = resp_valid && r_redirect;
    new_program_counter      = resp_valid ? r_newPc : '0;
    link_we                  = resp_valid && r_linkWe;
    link_rd                  = resp_valid ? r_linkRd : '0;
    link_data                = resp_valid ? r_linkData : '0;
    exception                = resp_valid && r_exception;
  end

endmodule

// File: tb/tb_branch_unit.sv
// Randomized self-checking bench for branch_unit; two instances (C_EXT=0 and C_EXT=1)
// run in lockstep against a behavioural model built from encoded immediates.
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_valid, flush, resp_ready;
  logic [31:0] instruction, program_counter;

  logic        startReady[2], respValid[2], loadNpc[2], linkWe[2], excOut[2];
  logic [4:0]  sel1[2], sel2[2], linkRd[2];
  logic [31:0] rdData1[2], rdData2[2], newPc[2], linkData[2];
  logic [31:0] regs[32];

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    int         kind;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2;
    int         imm;
    logic [31:0] pc;
    logic [31:0] raw;
  } op_t;

  typedef struct {
    logic        exc, redirect, lwe, checkNpc;
    logic [31:0] npc, ldata;
    logic [4:0]  lrd;
  } exp_t;

  exp_t expd[2];

  always #5 clk = ~clk;

  assign rdData1[0] = regs[sel1[0]];
  assign rdData2[0] = regs[sel2[0]];
  assign rdData1[1] = regs[sel1[1]];
  assign rdData2[1] = regs[sel2[1]];

  branch_unit #(.XLEN(32), .REG_SELECT_LEN(5), .C_EXT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(startReady[0]),
    .instruction(instruction), .program_counter(program_counter), .flush(flush),
    .register_1(sel1[0]), .register_2(sel2[0]),
    .register_data_1(rdData1[0]), .register_data_2(rdData2[0]),
    .resp_valid(respValid[0]), .resp_ready(resp_ready),
    .load_new_program_counter(loadNpc[0]), .new_program_counter(newPc[0]),
    .link_we(linkWe[0]), .link_rd(linkRd[0]), .link_data(linkData[0]), .exception(excOut[0])
  );

  branch_unit #(.XLEN(32), .REG_SELECT_LEN(5), .C_EXT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(startReady[1]),
    .instruction(instruction), .program_counter(program_counter), .flush(flush),
    .register_1(sel1[1]), .register_2(sel2[1]),
    .register_data_1(rdData1[1]), .register_data_2(rdData2[1]),
    .resp_valid(respValid[1]), .resp_ready(resp_ready),
    .load_new_program_counter(loadNpc[1]), .new_program_counter(newPc[1]),
    .link_we(linkWe[1]), .link_rd(linkRd[1]), .link_data(linkData[1]), .exception(excOut[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic op_t mkOp(int kind, logic [2:0] f3, logic [4:0] rd, logic [4:0] rs1,
                               logic [4:0] rs2, int imm, logic [31:0] pc);
    op_t o;
    o.kind = kind; o.f3 = f3; o.rd = rd; o.rs1 = rs1; o.rs2 = rs2;
    o.imm = imm; o.pc = pc; o.raw = 32'h0;
    return o;
  endfunction

  // Builds the instruction word from fields and a plain integer immediate
  function automatic logic [31:0] encode(op_t o);
    logic [12:0] b;
    logic [20:0] j;
    logic [11:0] i;
    b = 13'(o.imm);
    j = 21'(o.imm);
    i = 12'(o.imm);
    case (o.kind)
      0:       return {b[12], b[10:5], o.rs2, o.rs1, o.f3, b[4:1], b[11], 7'b1100011};
      1:       return {j[20], j[10:1], j[11], j[19:12], o.rd, 7'b1101111};
      2:       return {i, o.rs1, o.f3, o.rd, 7'b1100111};
      default: return o.raw;
    endcase
  endfunction

  function automatic exp_t model(op_t o, logic [31:0] a, logic [31:0] bv, int cext);
    exp_t e;
    logic legal, taken, jump;
    logic [31:0] target, pc4;
    pc4 = o.pc + 32'd4;
    legal = 1'b0; taken = 1'b0; jump = 1'b0; target = pc4;
    case (o.kind)
      0: begin
        legal  = !(o.f3 == 3'd2 || o.f3 == 3'd3);
        target = o.pc + 32'(o.imm);
        case (o.f3)
          3'd0: taken = (a == bv);
          3'd1: taken = (a != bv);
          3'd4: taken = ($signed(a) < $signed(bv));
          3'd5: taken = !($signed(a) < $signed(bv));
          3'd6: taken = (a < bv);
          3'd7: taken = !(a < bv);
          default: taken = 1'b0;
        endcase
      end
      1: begin legal = 1'b1; jump = 1'b1; taken = 1'b1; target = o.pc + 32'(o.imm); end
      2: begin
        legal = (o.f3 == 3'd0); jump = 1'b1; taken = 1'b1;
        target = (a + 32'(o.imm)) & 32'hFFFF_FFFE;
      end
      default: legal = 1'b0;
    endcase
    e.exc = 1'b0; e.redirect = 1'b0; e.lwe = 1'b0; e.checkNpc = 1'b1;
    e.npc = pc4; e.ldata = pc4; e.lrd = o.rd;
    if (!legal) begin
      e.exc = 1'b1; e.checkNpc = 1'b0;
    end else if (taken && cext == 0 && target[1]) begin
      e.exc = 1'b1; e.npc = target;
    end else if (taken) begin
      e.redirect = 1'b1; e.npc = target; e.lwe = jump && (o.rd != 5'd0);
    end
    return e;
  endfunction

  task automatic checkResults(input string when);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("%s.dut%0d.resp_valid", when, k), 32'(respValid[k]), 32'd1);
      checkOutput($sformatf("%s.dut%0d.exception", when, k), 32'(excOut[k]), 32'(expd[k].exc));
      checkOutput($sformatf("%s.dut%0d.redirect", when, k), 32'(loadNpc[k]), 32'(expd[k].redirect));
      if (expd[k].checkNpc)
        checkOutput($sformatf("%s.dut%0d.new_pc", when, k), newPc[k], expd[k].npc);
      checkOutput($sformatf("%s.dut%0d.link_we", when, k), 32'(linkWe[k]), 32'(expd[k].lwe));
      if (expd[k].lwe) begin
        checkOutput($sformatf("%s.dut%0d.link_rd", when, k), 32'(linkRd[k]), 32'(expd[k].lrd));
        checkOutput($sformatf("%s.dut%0d.link_data", when, k), linkData[k], expd[k].ldata);
      end
    end
  endtask

  task automatic applyStimulus(input op_t o, input int hold);
    logic [31:0] w;
    int lat;
    bit seen;
    w = encode(o);
    for (int k = 0; k < 2; k++) expd[k] = model(o, regs[w[19:15]], regs[w[24:20]], k);
    @(negedge clk);
    checkOutput("start_ready_idle", 32'(startReady[0]), 32'd1);
    start_valid = 1'b1; instruction = w; program_counter = o.pc;
    @(negedge clk);
    start_valid = 1'b0; instruction = $urandom(); program_counter = $urandom();
    checkOutput("rs1_select", 32'(sel1[0]), 32'(w[19:15]));
    checkOutput("rs2_select", 32'(sel2[1]), 32'(w[24:20]));
    lat = 1; seen = 0;
    while (!seen && lat < 8) begin
      if (respValid[0]) seen = 1;
      else begin @(negedge clk); lat++; end
    end
    checkOutput("latency", 32'(lat), 32'd3);
    if (!seen) begin
      flush = 1'b1; @(negedge clk); flush = 1'b0;
      return;
    end
    checkResults("first");
    for (int c = 0; c < hold; c++) begin
      start_valid = 1'b1; instruction = $urandom(); program_counter = $urandom();
      @(negedge clk);
      checkOutput("start_ready_busy", 32'(startReady[0]), 32'd0);
      checkResults("hold");
    end
    start_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checkOutput("resp_valid_after", 32'(respValid[0]), 32'd0);
    checkOutput("idle_ready", 32'(startReady[1]), 32'd1);
    checkOutput("link_we_idle", 32'(linkWe[0]), 32'd0);
  endtask

  task automatic checkQuiet(input string tag);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("%s.dut%0d.resp_valid", tag, k), 32'(respValid[k]), 32'd0);
      checkOutput($sformatf("%s.dut%0d.start_ready", tag, k), 32'(startReady[k]), 32'd1);
      checkOutput($sformatf("%s.dut%0d.sel1", tag, k), 32'(sel1[k]), 32'd0);
      checkOutput($sformatf("%s.dut%0d.sel2", tag, k), 32'(sel2[k]), 32'd0);
      checkOutput($sformatf("%s.dut%0d.redirect", tag, k), 32'(loadNpc[k]), 32'd0);
      checkOutput($sformatf("%s.dut%0d.new_pc", tag, k), newPc[k], 32'd0);
      checkOutput($sformatf("%s.dut%0d.link", tag, k), {linkData[k][30:0], linkWe[k]}, 32'd0);
      checkOutput($sformatf("%s.dut%0d.exception", tag, k), 32'(excOut[k]), 32'd0);
    end
  endtask

  function automatic logic [31:0] randValue();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 3));
      1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      2:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  function automatic op_t randomOp();
    op_t o;
    int sel;
    logic [31:0] r;
    o = mkOp(0, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)), 0, $urandom() & 32'hFFFF_FFFC);
    sel = int'($urandom_range(0, 9));
    if (sel <= 4) begin
      o.kind = 0; o.imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
    end else if (sel <= 6) begin
      o.kind = 1; o.imm = (int'($urandom_range(0, 1048575)) - 524288) * 2;
    end else if (sel <= 8) begin
      o.kind = 2; o.imm = int'($urandom_range(0, 4095)) - 2048;
      if ($urandom_range(0, 7) != 0) o.f3 = 3'd0;
    end else begin
      o.kind = 3;
      r = $urandom();
      while (r[6:0] == 7'b1100011 || r[6:0] == 7'b1101111 || r[6:0] == 7'b1100111) r = $urandom();
      o.raw = r;
    end
    return o;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    op_t o;
    logic [31:0] w;
    rst_n = 1'b0; start_valid = 1'b0; flush = 1'b0; resp_ready = 1'b0;
    instruction = 32'h0; program_counter = 32'h0;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h0101_0101;
    regs[0] = 32'h0;
    @(negedge clk); @(negedge clk);
    checkQuiet("reset");
    rst_n = 1'b1;
    @(negedge clk);

    regs[1] = 32'd5; regs[2] = 32'd5;
    applyStimulus(mkOp(0, 3'd0, 5'd0, 5'd1, 5'd2, -8, 32'h100), 0);
    regs[3] = 32'hFFFF_FFFF; regs[4] = 32'd1;
    applyStimulus(mkOp(0, 3'd4, 5'd0, 5'd3, 5'd4, 16, 32'h200), 0);
    applyStimulus(mkOp(0, 3'd6, 5'd0, 5'd3, 5'd4, 16, 32'h200), 0);
    applyStimulus(mkOp(0, 3'd5, 5'd0, 5'd3, 5'd4, 16, 32'h200), 1);
    applyStimulus(mkOp(0, 3'd7, 5'd0, 5'd3, 5'd4, 16, 32'h200), 0);
    regs[5] = 32'h1003;
    applyStimulus(mkOp(2, 3'd0, 5'd1, 5'd5, 5'd0, 0, 32'h300), 0);
    applyStimulus(mkOp(1, 3'd0, 5'd0, 5'd0, 5'd0, 8, 32'hFFFF_FFFC), 0);
    applyStimulus(mkOp(1, 3'd0, 5'd7, 5'd0, 5'd0, 8, 32'hFFFF_FFFC), 0);
    applyStimulus(mkOp(0, 3'd1, 5'd0, 5'd1, 5'd3, 32, 32'h400), 5);
    applyStimulus(mkOp(0, 3'd2, 5'd0, 5'd1, 5'd2, 8, 32'h500), 0);
    applyStimulus(mkOp(2, 3'd1, 5'd4, 5'd1, 5'd0, 8, 32'h500), 0);
    o = mkOp(3, 3'd0, 5'd0, 5'd0, 5'd0, 0, 32'h600);
    o.raw = 32'h0020_81B3;
    applyStimulus(o, 0);

    for (int n = 0; n < 200; n++) begin
      for (int i = 1; i < 32; i++) regs[i] = randValue();
      applyStimulus(randomOp(), int'($urandom_range(0, 3)));
    end

    // flush while in EXEC discards the operation
    w = encode(mkOp(0, 3'd0, 5'd0, 5'd1, 5'd2, 8, 32'h700));
    @(negedge clk);
    start_valid = 1'b1; instruction = w; program_counter = 32'h700;
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkQuiet("flush_exec");
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("flush_no_resp", 32'(respValid[0] | respValid[1]), 32'd0);
    end

    // flush beats a simultaneous start
    start_valid = 1'b1; flush = 1'b1; instruction = w;
    @(negedge clk);
    start_valid = 1'b0; flush = 1'b0;
    checkQuiet("flush_vs_start");

    // asynchronous reset during READ
    start_valid = 1'b1; instruction = w; program_counter = 32'h800;
    @(negedge clk);
    start_valid = 1'b0;
    checkOutput("reset_pre_sel1", 32'(sel1[0]), 32'(w[19:15]));
    rst_n = 1'b0;
    #1;
    checkQuiet("reset_async");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkQuiet("reset_after");
    end

    regs[1] = 32'd9; regs[2] = 32'd9;
    applyStimulus(mkOp(0, 3'd0, 5'd0, 5'd1, 5'd2, 12, 32'h900), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
